// File: rtl/lift_scan_ctrl.sv
// lift_scan_ctrl: single-car elevator controller using a scan (elevator) policy.
// The car keeps its travel direction while requests remain ahead of it, then reverses.
//
// Ports:
//   clk        single clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset; abandons any trip and drops all requests
//   req_valid  request strobe, one request per high cycle
//   req_floor  target floor of the request
//   req_kind   00 car call, 01 hall up, 10 hall down, 11 reserved (ignored)
//   floor      current floor of the car
//   out        motion: 00 up, 01 down, 10 stay
//   door_open  high for every cycle the doors are open
//   done       one-cycle pulse on the first door cycle of each stop
//   pending    bit f set while any request is latched for floor f
module lift_scan_ctrl #(
    parameter int FLOORS     = 8,
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 6,
    localparam int FW        = (FLOORS > 1) ? $clog2(FLOORS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [FW-1:0]     req_floor,
    input  logic [1:0]        req_kind,
    output logic [FW-1:0]     floor,
    output logic [1:0]        out,
    output logic              door_open,
    output logic              done,
    output logic [FLOORS-1:0] pending
);

    localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
    localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;

    localparam logic [TW-1:0] TRAV_LAST = TW'(TRAVEL_CYC - 1);
    localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYC - 1);
    localparam logic [FW-1:0] ONE_F     = FW'(1);
    localparam logic [FW-1:0] BOT_F     = FW'(0);
    localparam logic [FW-1:0] TOP_F     = FW'(FLOORS - 1);
    localparam logic [FW:0]   FLOORS_X  = (FW + 1)'(FLOORS);

    localparam logic [1:0] KIND_CAR = 2'b00;
    localparam logic [1:0] KIND_UP  = 2'b01;
    localparam logic [1:0] KIND_DN  = 2'b10;
    localparam logic [1:0] KIND_RSV = 2'b11;

    localparam logic [1:0] OUT_UP   = 2'b00;
    localparam logic [1:0] OUT_DOWN = 2'b01;
    localparam logic [1:0] OUT_STAY = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MOVE = 2'b01,
        ST_DOOR = 2'b10
    } state_t;

    // One-hot decode of a floor number; out-of-range floors decode to zero.
    function automatic logic [FLOORS-1:0] onehot(input logic [FW-1:0] f);
        logic [FLOORS-1:0] v;
        v = '0;
        for (int i = 0; i < FLOORS; i++) begin
            v[i] = (FW'(i) == f);
        end
        return v;
    endfunction

    function automatic logic bit_at(input logic [FLOORS-1:0] vec, input logic [FW-1:0] f);
        return |(vec & onehot(f));
    endfunction

    function automatic logic any_above(input logic [FLOORS-1:0] vec, input logic [FW-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            hit = hit | (vec[i] & (FW'(i) > f));
        end
        return hit;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] vec, input logic [FW-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            hit = hit | (vec[i] & (FW'(i) < f));
        end
        return hit;
    endfunction

    state_t            state_r, state_nx;
    logic              dir_up_r, dir_nx;
    logic              served_up_r, served_nx;
    logic [FW-1:0]     floor_r, floor_nx;
    logic [TW-1:0]     trav_cnt_r, trav_nx;
    logic [DW-1:0]     door_cnt_r, door_nx;
    logic [FLOORS-1:0] car_req_r, up_req_r, dn_req_r;
    logic [1:0]        out_r, out_nx;
    logic              door_open_r, done_r;
    logic              stop_s;

    logic [FLOORS-1:0] pend_s, req_vec_s;
    logic [FLOORS-1:0] car_set_s, up_set_s, dn_set_s;
    logic [FLOORS-1:0] car_clr_s, up_clr_s, dn_clr_s;
    logic              req_ok_s, absorb_s;
    logic [FW-1:0]     step_floor_s;
    logic              at_end_s, cur_above_s, cur_below_s, cur_match_s, cur_opp_s;
    logic              fn_car_s, fn_match_s, fn_opp_s, fn_ahead_s;

    assign pend_s = car_req_r | up_req_r | dn_req_r;

    // A request is dropped if reserved, off the shaft, or a hall call pointing out of the shaft.
    assign req_ok_s = req_valid && (req_kind != KIND_RSV) && ({1'b0, req_floor} < FLOORS_X)
                      && !((req_kind == KIND_UP) && (req_floor == TOP_F))
                      && !((req_kind == KIND_DN) && (req_floor == BOT_F));

    // While the doors are open, a same-floor call the current stop already serves only
    // extends the door time instead of being latched.
    assign absorb_s = (state_r == ST_DOOR) && req_ok_s && (req_floor == floor_r)
                      && ((req_kind == KIND_CAR)
                          || ((req_kind == KIND_UP) && served_up_r)
                          || ((req_kind == KIND_DN) && !served_up_r));

    assign req_vec_s = (req_ok_s && !absorb_s) ? onehot(req_floor) : '0;
    assign car_set_s = (req_kind == KIND_CAR) ? req_vec_s : '0;
    assign up_set_s  = (req_kind == KIND_UP)  ? req_vec_s : '0;
    assign dn_set_s  = (req_kind == KIND_DN)  ? req_vec_s : '0;

    assign car_clr_s = stop_s ? onehot(floor_nx) : '0;
    assign up_clr_s  = (stop_s && served_nx)  ? onehot(floor_nx) : '0;
    assign dn_clr_s  = (stop_s && !served_nx) ? onehot(floor_nx) : '0;

    assign cur_above_s = any_above(pend_s, floor_r);
    assign cur_below_s = any_below(pend_s, floor_r);
    assign cur_match_s = bit_at(dir_up_r ? up_req_r : dn_req_r, floor_r);
    assign cur_opp_s   = bit_at(dir_up_r ? dn_req_r : up_req_r, floor_r);

    // Look-ahead at the floor the car is about to reach.
    assign at_end_s     = dir_up_r ? (floor_r == TOP_F) : (floor_r == BOT_F);
    assign step_floor_s = dir_up_r ? (floor_r + ONE_F) : (floor_r - ONE_F);
    assign fn_car_s     = bit_at(car_req_r, step_floor_s);
    assign fn_match_s   = bit_at(dir_up_r ? up_req_r : dn_req_r, step_floor_s);
    assign fn_opp_s     = bit_at(dir_up_r ? dn_req_r : up_req_r, step_floor_s);
    assign fn_ahead_s   = dir_up_r ? any_above(pend_s, step_floor_s)
                                   : any_below(pend_s, step_floor_s);

    // Next-state, counters, stop decision and motion output.
    always_comb begin
        state_nx  = state_r;
        dir_nx    = dir_up_r;
        served_nx = served_up_r;
        floor_nx  = floor_r;
        trav_nx   = trav_cnt_r;
        door_nx   = door_cnt_r;
        stop_s    = 1'b0;
        out_nx    = OUT_STAY;
        case (state_r)
            ST_IDLE: begin
                trav_nx = '0;
                door_nx = '0;
                if (bit_at(pend_s, floor_r)) begin
                    state_nx  = ST_DOOR;
                    stop_s    = 1'b1;
                    served_nx = dir_up_r ^ (!cur_match_s && cur_opp_s);
                end else if (cur_above_s && (dir_up_r || !cur_below_s)) begin
                    state_nx = ST_MOVE;
                    dir_nx   = 1'b1;
                end else if (cur_below_s) begin
                    state_nx = ST_MOVE;
                    dir_nx   = 1'b0;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_MOVE: begin
                door_nx = '0;
                if (trav_cnt_r != TRAV_LAST) begin
                    trav_nx = trav_cnt_r + TW'(1);
                end else if (at_end_s) begin
                    // Cannot step past the shaft end; park instead.
                    trav_nx  = '0;
                    state_nx = ST_IDLE;
                end else begin
                    trav_nx  = '0;
                    floor_nx = step_floor_s;
                    if (fn_car_s || fn_match_s || (!fn_ahead_s && fn_opp_s)) begin
                        state_nx = ST_DOOR;
                        stop_s   = 1'b1;
                        // Reversal stop: the car will leave the other way, so serve the opposite hall call.
                        served_nx = dir_up_r ^ (!fn_match_s && !fn_ahead_s && fn_opp_s);
                    end else if (fn_ahead_s) begin
                        state_nx = ST_MOVE;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_DOOR: begin
                trav_nx = '0;
                if (absorb_s) begin
                    door_nx = '0;
                end else if (door_cnt_r != DOOR_LAST) begin
                    door_nx = door_cnt_r + DW'(1);
                end else begin
                    door_nx = '0;
                    if (dir_up_r ? cur_above_s : cur_below_s) begin
                        state_nx = ST_MOVE;
                    end else if (dir_up_r ? cur_below_s : cur_above_s) begin
                        state_nx = ST_MOVE;
                        dir_nx   = !dir_up_r;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                trav_nx  = '0;
                door_nx  = '0;
            end
        endcase
        if (state_nx == ST_MOVE) begin
            out_nx = dir_nx ? OUT_UP : OUT_DOWN;
        end else begin
            out_nx = OUT_STAY;
        end
    end

    // FSM state, position, direction and timers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            dir_up_r    <= 1'b1;
            served_up_r <= 1'b1;
            floor_r     <= '0;
            trav_cnt_r  <= '0;
            door_cnt_r  <= '0;
        end else begin
            state_r     <= state_nx;
            dir_up_r    <= dir_nx;
            served_up_r <= served_nx;
            floor_r     <= floor_nx;
            trav_cnt_r  <= trav_nx;
            door_cnt_r  <= door_nx;
        end
    end

    // Request vectors: a new request beats a clear of the same bit on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_req_r <= '0;
            up_req_r  <= '0;
            dn_req_r  <= '0;
        end else begin
            car_req_r <= (car_req_r & ~car_clr_s) | car_set_s;
            up_req_r  <= (up_req_r & ~up_clr_s) | up_set_s;
            dn_req_r  <= (dn_req_r & ~dn_clr_s) | dn_set_s;
        end
    end

    // Output registers, loaded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= OUT_STAY;
            door_open_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            out_r       <= out_nx;
            door_open_r <= (state_nx == ST_DOOR);
            done_r      <= (state_nx == ST_DOOR) && (state_r != ST_DOOR);
        end
    end

    assign floor     = floor_r;
    assign out       = out_r;
    assign door_open = door_open_r;
    assign done      = done_r;
    assign pending   = pend_s;

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// Directed bench for lift_scan_ctrl (4 floors, 4-cycle travel, 6-cycle door).
// Expected stop floors and floor steps are queued as stimulus is driven and
// checked by a negedge monitor as the DUT produces them.
module tb_lift_scan_ctrl;

    localparam int FLOORS     = 4;
    localparam int TRAVEL_CYC = 4;
    localparam int DOOR_CYC   = 6;

    localparam logic [1:0] K_CAR = 2'b00;
    localparam logic [1:0] K_UP  = 2'b01;
    localparam logic [1:0] K_DN  = 2'b10;
    localparam logic [1:0] K_RSV = 2'b11;
    localparam logic [1:0] O_UP   = 2'b00;
    localparam logic [1:0] O_STAY = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_floor = 2'b00;
    logic [1:0] req_kind = 2'b00;
    logic [1:0] floor;
    logic [1:0] out;
    logic       door_open;
    logic       done;
    logic [3:0] pending;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int up_cyc = 0;
    int door_cyc = 0;

    logic [1:0] exp_stop_q[$];
    logic [1:0] exp_move_q[$];
    logic [1:0] prev_floor = 2'b00;

    lift_scan_ctrl #(
        .FLOORS    (FLOORS),
        .TRAVEL_CYC(TRAVEL_CYC),
        .DOOR_CYC  (DOOR_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_floor(req_floor),
        .req_kind (req_kind),
        .floor    (floor),
        .out      (out),
        .door_open(door_open),
        .done     (done),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] k, input logic [1:0] f);
        req_kind  = k;
        req_floor = f;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_stops(input int budget);
        int n;
        n = 0;
        while (exp_stop_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("stop_timeout", 32'(exp_stop_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_floor", 32'(floor), 32'd0);
        check("rst_pend", 32'(pending), 32'd0);
        check("rst_out", 32'(out), 32'(O_STAY));
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor: stop floors, floor steps, legal motion code, activity counters.
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_legal", (out === 2'b11) ? 32'd1 : 32'd0, 32'd0);
            if (out === O_UP) up_cyc++;
            if (door_open === 1'b1) door_cyc++;
            if (done === 1'b1) begin
                done_cnt++;
                if (exp_stop_q.size() != 0) check("stop_floor", 32'(floor), 32'(exp_stop_q.pop_front()));
                else check("done_unexpected", 32'(done), 32'd0);
            end
            if (floor !== prev_floor) begin
                if (exp_move_q.size() != 0) check("floor_step", 32'(floor), 32'(exp_move_q.pop_front()));
                else check("floor_unexpected", 32'(floor), 32'(prev_floor));
            end
        end
        prev_floor <= floor;
    end

    initial begin
        // Reset state and quiet idle.
        repeat (3) tick();
        @(negedge clk);
        check("rst_floor0", 32'(floor), 32'd0);
        check("rst_out0", 32'(out), 32'(O_STAY));
        check("rst_door0", 32'(door_open), 32'd0);
        check("rst_done0", 32'(done), 32'd0);
        check("rst_pend0", 32'(pending), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (50) tick();
        @(negedge clk);
        check("idle_floor", 32'(floor), 32'd0);
        check("idle_out", 32'(out), 32'(O_STAY));
        check("idle_done", 32'(done_cnt), 32'd0);

        // Car call to the top floor from floor 0.
        done_cnt = 0; up_cyc = 0; door_cyc = 0;
        exp_move_q.push_back(2'd1); exp_move_q.push_back(2'd2); exp_move_q.push_back(2'd3);
        exp_stop_q.push_back(2'd3);
        tick();
        send(K_CAR, 2'd3);
        @(negedge clk);
        check("t2_pend", 32'(pending), 32'b1000);
        wait_stops(100);
        repeat (DOOR_CYC + 4) tick();
        @(negedge clk);
        check("t2_up_cyc", 32'(up_cyc), 32'd12);
        check("t2_door_cyc", 32'(door_cyc), 32'd6);
        check("t2_done_cnt", 32'(done_cnt), 32'd1);
        check("t2_pend_end", 32'(pending), 32'd0);
        check("t2_out", 32'(out), 32'(O_STAY));
        check("t2_floor", 32'(floor), 32'd3);
        check("t2_moves_left", 32'(exp_move_q.size()), 32'd0);

        // Hall down at 2, then car call 1 while moving up: stop 1, reversal stop 2.
        do_reset();
        done_cnt = 0;
        exp_move_q.push_back(2'd1); exp_move_q.push_back(2'd2);
        exp_stop_q.push_back(2'd1); exp_stop_q.push_back(2'd2);
        send(K_DN, 2'd2);
        tick();
        send(K_CAR, 2'd1);
        wait_stops(200);
        repeat (DOOR_CYC + 4) tick();
        @(negedge clk);
        check("t3_done_cnt", 32'(done_cnt), 32'd2);
        check("t3_pend", 32'(pending), 32'd0);
        check("t3_out", 32'(out), 32'(O_STAY));
        check("t3_floor", 32'(floor), 32'd2);
        check("t3_moves_left", 32'(exp_move_q.size()), 32'd0);

        // From floor 2: car 3 then car 0 on consecutive cycles.
        done_cnt = 0;
        exp_move_q.push_back(2'd3); exp_move_q.push_back(2'd2);
        exp_move_q.push_back(2'd1); exp_move_q.push_back(2'd0);
        exp_stop_q.push_back(2'd3); exp_stop_q.push_back(2'd0);
        tick();
        req_kind = K_CAR; req_floor = 2'd3; req_valid = 1'b1;
        tick();
        req_floor = 2'd0;
        tick();
        req_valid = 1'b0;
        wait_stops(300);
        repeat (DOOR_CYC + 4) tick();
        @(negedge clk);
        check("t4_done_cnt", 32'(done_cnt), 32'd2);
        check("t4_pend", 32'(pending), 32'd0);
        check("t4_floor", 32'(floor), 32'd0);
        check("t4_out", 32'(out), 32'(O_STAY));
        check("t4_moves_left", 32'(exp_move_q.size()), 32'd0);

        // Requests that must be ignored.
        done_cnt = 0;
        tick();
        send(K_UP, 2'd3);
        @(negedge clk);
        check("t5_up_top", 32'(pending), 32'd0);
        send(K_DN, 2'd0);
        @(negedge clk);
        check("t5_dn_bot", 32'(pending), 32'd0);
        send(K_RSV, 2'd1);
        @(negedge clk);
        check("t5_rsv", 32'(pending), 32'd0);
        repeat (5) tick();
        @(negedge clk);
        check("t5_out", 32'(out), 32'(O_STAY));
        check("t5_done", 32'(done_cnt), 32'd0);

        // Same-floor call: door two cycles after request; repeat call extends door.
        done_cnt = 0; door_cyc = 0;
        exp_stop_q.push_back(2'd0);
        tick();
        send(K_CAR, 2'd0);
        @(negedge clk);
        check("t7_door_early", 32'(door_open), 32'd0);
        tick();
        @(negedge clk);
        check("t7_door_open", 32'(door_open), 32'd1);
        check("t7_done_pulse", 32'(done), 32'd1);
        tick();
        tick();
        send(K_CAR, 2'd0);
        @(negedge clk);
        check("t7_absorb_pend", 32'(pending), 32'd0);
        check("t7_still_open", 32'(door_open), 32'd1);
        repeat (12) tick();
        @(negedge clk);
        check("t7_door_cyc", 32'(door_cyc), 32'd9);
        check("t7_done_cnt", 32'(done_cnt), 32'd1);
        check("t7_pend_end", 32'(pending), 32'd0);
        check("t7_out", 32'(out), 32'(O_STAY));

        // Reset in the middle of travel between floors 1 and 2.
        done_cnt = 0;
        exp_move_q.push_back(2'd1);
        tick();
        send(K_CAR, 2'd3);
        repeat (7) tick();
        check("t6_pre_floor", 32'(floor), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_floor", 32'(floor), 32'd0);
        check("t6_pend", 32'(pending), 32'd0);
        check("t6_out", 32'(out), 32'(O_STAY));
        check("t6_door", 32'(door_open), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        @(negedge clk);
        check("t6_no_done", 32'(done_cnt), 32'd0);
        check("t6_floor_end", 32'(floor), 32'd0);
        check("t6_out_end", 32'(out), 32'(O_STAY));
        check("t6_pend_end", 32'(pending), 32'd0);
        check("t6_moves_left", 32'(exp_move_q.size()), 32'd0);
        check("t6_stops_left", 32'(exp_stop_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lift_scan_ctrl.md
LIFT_SCAN_CTRL -- requirements
Module: lift_scan_ctrl

Interface
REQ-001 Parameter FLOORS, default 8, number of floors (>=2); floors numbered 0..FLOORS-1.
REQ-002 Parameter TRAVEL_CYC, default 4, clock cycles to travel one floor (>=1).
REQ-003 Parameter DOOR_CYC, default 6, clock cycles doors stay open (>=1).
REQ-004 Derived FW = max(1, clog2(FLOORS)); not overridable.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 req_valid  input  1  request strobe; each high cycle is one request.
REQ-008 req_floor  input  FW  target floor of the request.
REQ-009 req_kind  input  2  00 car call, 01 hall up, 10 hall down, 11 reserved.
REQ-010 floor  output  FW  current floor.
REQ-011 out  output  2  motion: UP=00, DOWN=01, STAY=10; 11 never driven.
REQ-012 door_open  output  1  high throughout DOOR state.
REQ-013 done  output  1  one-cycle pulse on the first DOOR cycle of each stop.
REQ-014 pending  output  FLOORS  bit f = any car/up/down request latched for floor f.

Function
REQ-015 Three internal vectors car_req, up_req, dn_req (FLOORS bits each) and a direction flag dir_up shall hold state.
REQ-016 A request shall set its bit at the next clock edge; visible on pending one cycle after req_valid.
REQ-017 Ignored requests: req_kind 11, req_floor >= FLOORS, hall up at floor FLOORS-1, hall down at floor 0.
REQ-018 FSM states IDLE, MOVE, DOOR; dir_up changes only on entering MOVE.
REQ-019 IDLE, request at current floor -> DOOR next cycle; else requests above and (dir_up or none below) -> MOVE up; else requests below -> MOVE down; else stay IDLE.
REQ-020 MOVE: travel counter counts TRAVEL_CYC cycles; on the last, floor increments (up) or decrements (down).
REQ-021 On arrival, stop (-> DOOR) if car_req[floor], or hall bit matching dir_up set, or no requests ahead and opposite hall bit set; else continue MOVE with reloaded counter.
REQ-022 Entering DOOR shall clear car_req[floor] and the hall bit for the departure direction; at a reversal stop the opposite hall bit is cleared instead.
REQ-023 DOOR lasts DOOR_CYC cycles; a same-floor request matching the served direction or a car call arriving during DOOR is absorbed (not latched) and reloads the door timer.
REQ-024 DOOR exit: requests ahead in dir_up -> MOVE same direction; else requests behind -> MOVE reversed; else IDLE.
REQ-025 floor shall never go below 0 or above FLOORS-1; a move is never started without a request in that direction.
REQ-026 out = UP in MOVE with dir_up=1, DOWN in MOVE with dir_up=0, STAY in IDLE and DOOR.
REQ-027 A request set and its clear on the same edge for the same bit: set wins unless absorbed per REQ-023.
REQ-028 Latency: request at idle car's floor -> door_open/done 2 cycles after req_valid; one-floor trip -> arrival TRAVEL_CYC cycles after MOVE entry.

Reset
REQ-029 While rst_n low: floor=0, IDLE, dir_up=1, all request vectors cleared, out=STAY, door_open=0, done=0, counters 0.
REQ-030 Reset asserted mid-MOVE or mid-DOOR shall abandon the trip immediately and discard all pending requests.

Verification (FLOORS=4, TRAVEL_CYC=4, DOOR_CYC=6)
REQ-031 Reset release, no requests for 50 cycles -> floor=0, out=STAY, done never pulses.
REQ-032 Car call floor 3 from idle at 0 -> out=UP for 12 cycles, floor steps 1,2,3, done pulses once at 3, door_open 6 cycles, pending=0000, IDLE.
REQ-033 At floor 0 idle, hall down 2 then car 1 while moving up -> stops at 1 (car), passes none, stops at 2 (reversal, dn_req cleared), returns IDLE.
REQ-034 At floor 2 idle, car calls 3 and 0 same cycle order (3 first then 0) -> serves 3 upward, reverses, serves 0; out never 11.
REQ-035 Ignored inputs: hall up floor 3, hall down floor 0, kind 11 -> pending stays 0000, out=STAY.
REQ-036 rst_n pulsed low mid-travel between floors 1 and 2 -> floor=0, pending=0000, out=STAY immediately, no done after release.
